ram_sequencer: RTL and testbench

RAM_SEQUENCER -- requirements
Module: ram_sequencer

---
 rtl/gottagofast_pkg.sv | 27 ++
 rtl/refresh_timer.sv | 61 ++++++
 rtl/ram_sequencer.sv | 147 ++++++++++++++
 tb/tb_ram_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gottagofast_pkg.sv
// -----------------------------------------------------------------------------
// gottagofast_pkg
// Shared definitions for the DRAM sequencer: sequencer state encoding, default
// refresh parameters and the bank-to-RASn decode helper.
// -----------------------------------------------------------------------------
package gottagofast_pkg;

    // 108 cycles of the 7.09 MHz clock is about 15.2 us between refreshes.
    localparam int DEFAULT_REFRESH_INTERVAL = 108;
    localparam int DEFAULT_MAX_PENDING      = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACC_RAS,
        ACC_CAS,
        PRECHARGE,
        REF_CAS,
        REF_RAS,
        REF_PRE
    } seq_state_t;

    // Active-low row strobe pattern with only the selected bank low.
    function automatic logic [3:0] ras_select(input logic [1:0] bank);
        return ~(4'b0001 << bank);
    endfunction

endpackage

// File: rtl/refresh_timer.sv
// -----------------------------------------------------------------------------
// refresh_timer
// Free-running refresh interval timer plus a saturating count of refreshes
// that are owed to the DRAM.
//
// Ports
//   CLK       in   sequencer clock, rising edge
//   RESETn    in   asynchronous active-low reset
//   done      in   high for the one cycle in which a refresh completes
//   pending   out  number of refreshes owed (0..MAX_PENDING)
//   saturated out  pending has reached MAX_PENDING
// -----------------------------------------------------------------------------
module refresh_timer
    import gottagofast_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEFAULT_MAX_PENDING
) (
    input  logic                               CLK,
    input  logic                               RESETn,
    input  logic                               done,
    output logic [$clog2(MAX_PENDING + 1)-1:0] pending,
    output logic                               saturated
);

    localparam int TIMER_W = $clog2(REFRESH_INTERVAL);
    localparam int PEND_W  = $clog2(MAX_PENDING + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_INTERVAL - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX   = PEND_W'(MAX_PENDING);

    logic [TIMER_W-1:0] timer;
    logic               tick;

    // The tick is the wrap itself, so the first one lands REFRESH_INTERVAL
    // edges after reset release.
    assign tick      = (timer == TIMER_LAST);
    assign saturated = (pending == PEND_MAX);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            timer   <= '0;
            pending <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register in the design samples its inputs from the same edge.
            timer <= tick ? '0 : timer + 1'b1;

            // A new tick and a completed refresh cancel out. Ticks arriving
            // with the backlog full are dropped.
            if (tick && !done) begin
                if (!saturated) begin
                    pending <= pending + 1'b1;
                end
            end else if (done && !tick) begin
                pending <= pending - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_sequencer.sv
// -----------------------------------------------------------------------------
// ram_sequencer
// DRAM RAS/CAS sequencer for a 68000 bus: runs single-bank accesses and
// CAS-before-RAS refresh cycles, with refresh deferred while the bus is busy.
// All outputs are registered.
//
// Ports
//   CLK       in   7 MHz clock, rising edge
//   RESETn    in   asynchronous active-low reset
//   ACC_REQ   in   address matched and ASn low (synchronised)
//   ACC_BANK  in   RAS bank, captured when an access is granted
//   ASn, UDSn, LDSn, RWn  in  synchronised 68000 strobes
//   RASn      out  per-bank row strobes, active low
//   UCASn     out  upper-byte column strobe, active low
//   LCASn     out  lower-byte column strobe, active low
//   MUX_COL   out  0 = row address, 1 = column address
//   MEMWn     out  DRAM write enable, active low
//   ACC_ACK   out  DTACK enable
//   REF_BUSY  out  refresh sequence in progress
// -----------------------------------------------------------------------------
module ram_sequencer
    import gottagofast_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEFAULT_MAX_PENDING
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       ACC_REQ,
    input  logic [1:0] ACC_BANK,
    input  logic       ASn,
    input  logic       UDSn,
    input  logic       LDSn,
    input  logic       RWn,
    output logic [3:0] RASn,
    output logic       UCASn,
    output logic       LCASn,
    output logic       MUX_COL,
    output logic       MEMWn,
    output logic       ACC_ACK,
    output logic       REF_BUSY
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    seq_state_t        state;
    logic [1:0]        bank;
    logic [PEND_W-1:0] pending;
    logic              saturated;
    logic              ref_done;
    logic              start_ref;
    logic              acc_continue;

    assign ref_done = (state == REF_PRE);

    // A full backlog pre-empts a waiting access; otherwise refresh only runs
    // while the bus is quiet.
    assign start_ref = saturated || (!ACC_REQ && ASn && (pending != '0));

    // ACC_RAS always moves on to one CAS cycle, even if the request vanished.
    assign acc_continue = (state == ACC_RAS) || (ACC_REQ && !ASn);

    refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_PENDING      (MAX_PENDING)
    ) u_timer (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .done      (ref_done),
        .pending   (pending),
        .saturated (saturated)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            bank     <= '0;
            RASn     <= 4'hF;
            UCASn    <= 1'b1;
            LCASn    <= 1'b1;
            MUX_COL  <= 1'b0;
            MEMWn    <= 1'b1;
            ACC_ACK  <= 1'b0;
            REF_BUSY <= 1'b0;
        end else begin
            // Outputs are loaded with the values of the state being entered;
            // start from the all-inactive set and override below.
            RASn     <= 4'hF;
            UCASn    <= 1'b1;
            LCASn    <= 1'b1;
            MUX_COL  <= 1'b0;
            MEMWn    <= 1'b1;
            ACC_ACK  <= 1'b0;
            REF_BUSY <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_ref) begin
                        state    <= REF_CAS;
                        UCASn    <= 1'b0;
                        LCASn    <= 1'b0;
                        REF_BUSY <= 1'b1;
                    end else if (ACC_REQ) begin
                        state <= ACC_RAS;
                        bank  <= ACC_BANK;
                        RASn  <= ras_select(ACC_BANK);
                    end
                end

                ACC_RAS, ACC_CAS: begin
                    if (acc_continue) begin
                        state   <= ACC_CAS;
                        RASn    <= ras_select(bank);
                        MUX_COL <= 1'b1;
                        UCASn   <= UDSn;
                        LCASn   <= LDSn;
                        MEMWn   <= RWn;
                        ACC_ACK <= 1'b1;
                    end else begin
                        state <= PRECHARGE;
                    end
                end

                PRECHARGE: state <= IDLE;

                // CAS-before-RAS: CAS already low from REF_CAS, now all rows.
                REF_CAS: begin
                    state    <= REF_RAS;
                    RASn     <= 4'h0;
                    UCASn    <= 1'b0;
                    LCASn    <= 1'b0;
                    REF_BUSY <= 1'b1;
                end

                REF_RAS: begin
                    state    <= REF_PRE;
                    REF_BUSY <= 1'b1;
                end

                REF_PRE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ram_sequencer
// Scoreboarded bench for ram_sequencer: directed refresh/access/reset
// scenarios followed by randomized accesses with idle gaps.
// -----------------------------------------------------------------------------
module tb_ram_sequencer;
    import gottagofast_pkg::*;

    localparam int RI = 108;
    localparam int MP = 4;

    // {RASn, UCASn, LCASn, REF_BUSY} for REF_CAS, REF_RAS, REF_PRE, IDLE.
    localparam logic [6:0] REF_SEQ [4] = '{7'b1111_001, 7'b0000_001,
                                           7'b1111_111, 7'b1111_110};

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       ACC_REQ = 1'b0;
    logic [1:0] ACC_BANK = 2'd0;
    logic       ASn = 1'b1;
    logic       UDSn = 1'b1;
    logic       LDSn = 1'b1;
    logic       RWn = 1'b1;
    logic [3:0] RASn;
    logic       UCASn;
    logic       LCASn;
    logic       MUX_COL;
    logic       MEMWn;
    logic       ACC_ACK;
    logic       REF_BUSY;

    ram_sequencer #(
        .REFRESH_INTERVAL (RI),
        .MAX_PENDING      (MP)
    ) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .ACC_REQ  (ACC_REQ),
        .ACC_BANK (ACC_BANK),
        .ASn      (ASn),
        .UDSn     (UDSn),
        .LDSn     (LDSn),
        .RWn      (RWn),
        .RASn     (RASn),
        .UCASn    (UCASn),
        .LCASn    (LCASn),
        .MUX_COL  (MUX_COL),
        .MEMWn    (MEMWn),
        .ACC_ACK  (ACC_ACK),
        .REF_BUSY (REF_BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] bank;
        logic       u;
        logic       l;
        logic       rw;
    } acc_t;

    acc_t acc_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc;          // rising edges since reset release
    int   ref_count;    // refreshes completed since reset release
    logic prev_ack;
    logic prev_busy;
    int   busy_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_rasn(input logic [1:0] b);
        logic [3:0] r;
        r    = 4'hF;
        r[b] = 1'b0;
        return r;
    endfunction

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Monitor: pops the scoreboard on each new acknowledge and checks the
    // generic invariants of access and refresh cycles.
    always @(negedge CLK) begin
        if (!RESETn) begin
            prev_ack  <= 1'b0;
            prev_busy <= 1'b0;
            busy_len  <= 0;
            ref_count <= 0;
        end else begin
            if (ACC_ACK && !prev_ack) begin
                check("sb_entry_available", 32'(acc_q.size() != 0), 1);
                if (acc_q.size() != 0) begin
                    acc_t e;
                    e = acc_q.pop_front();
                    check("sb_rasn",  RASn,    exp_rasn(e.bank));
                    check("sb_ucasn", UCASn,   e.u);
                    check("sb_lcasn", LCASn,   e.l);
                    check("sb_memwn", MEMWn,   e.rw);
                    check("sb_mux",   MUX_COL, 1);
                end
            end
            if (ACC_ACK) check("one_bank_low", $countones(~RASn), 1);
            if (REF_BUSY) begin
                check("refresh_memwn", MEMWn, 1);
                busy_len <= busy_len + 1;
            end
            if (!REF_BUSY && prev_busy) begin
                check("refresh_length", busy_len, 3);
                ref_count <= ref_count + 1;
                busy_len  <= 0;
            end
            prev_ack  <= ACC_ACK;
            prev_busy <= REF_BUSY;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_rasn"},    RASn,     4'hF);
        check({tag, "_cas"},     {UCASn, LCASn}, 2'b11);
        check({tag, "_mux"},     MUX_COL,  0);
        check({tag, "_memwn"},   MEMWn,    1);
        check({tag, "_ack"},     ACC_ACK,  0);
        check({tag, "_busy"},    REF_BUSY, 0);
        check({tag, "_pending"}, dut.u_timer.pending, 0);
        check({tag, "_state"},   dut.state, IDLE);
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        ACC_REQ = 1'b0; ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; RWn = 1'b1; ACC_BANK = 2'd0;
        @(negedge CLK);
        check_reset_state("reset");
        @(negedge CLK);
        acc_q.delete();
        RESETn = 1'b1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    // Raise a request at a falling edge and wait (bounded) for the acknowledge.
    task automatic access_start(input logic [1:0] b, input logic u, input logic l,
                                input logic rw, input int exp_lat, output int busy_cycles);
        acc_t e;
        int   lat;
        ACC_REQ = 1'b1; ASn = 1'b0; ACC_BANK = b; UDSn = u; LDSn = l; RWn = rw;
        e.bank = b; e.u = u; e.l = l; e.rw = rw;
        acc_q.push_back(e);
        lat = 0;
        busy_cycles = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (REF_BUSY) busy_cycles++;
            if (exp_lat == 2 && lat == 1) begin
                check("grant_rasn", RASn, exp_rasn(b));
                check("grant_mux_row", MUX_COL, 0);
            end
        end while (!ACC_ACK && lat < 60);
        check("ack_seen", ACC_ACK, 1);
        if (exp_lat > 0) check("ack_latency", lat, exp_lat);
    endtask

    task automatic access_end();
        ACC_REQ = 1'b0;
        ASn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bc;
        acc_t e;

        // Idle after reset: first tick, then one full refresh sequence.
        do_reset();
        wait_cyc(RI - 1);
        check("pre_tick_pending", dut.u_timer.pending, 0);
        @(negedge CLK);
        check("first_tick_pending", dut.u_timer.pending, 1);
        check("first_tick_idle", dut.state, IDLE);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("refresh_step%0d", i), {RASn, UCASn, LCASn, REF_BUSY}, REF_SEQ[i]);
            if (i == 2) check("pending_in_ref_pre", dut.u_timer.pending, 1);
        end
        check("pending_after_refresh", dut.u_timer.pending, 0);

        // Reset pulse in the middle of REF_RAS abandons the refresh at once.
        do_reset();
        wait_cyc(RI + 2);
        check("in_ref_ras", RASn, 4'h0);
        #1 RESETn = 1'b0;
        #1 check_reset_state("async_reset");
        do_reset();

        // Basic write access to bank 2, upper byte only.
        access_start(2'd2, 1'b0, 1'b1, 1'b0, 2, bc);
        check("no_refresh_before_ack", bc, 0);
        repeat (2) @(negedge CLK);
        access_end();
        repeat (3) @(negedge CLK);
        check("back_to_idle", dut.state, IDLE);

        // Request withdrawn during ACC_RAS: one CAS cycle, PRECHARGE, IDLE.
        ACC_REQ = 1'b1; ASn = 1'b0; ACC_BANK = 2'd1; UDSn = 1'b1; LDSn = 1'b0; RWn = 1'b1;
        e.bank = 2'd1; e.u = 1'b1; e.l = 1'b0; e.rw = 1'b1;
        acc_q.push_back(e);
        @(negedge CLK);
        check("drop_state_ras", dut.state, ACC_RAS);
        access_end();
        @(negedge CLK);
        check("drop_state_cas", dut.state, ACC_CAS);
        check("drop_ack_high", ACC_ACK, 1);
        @(negedge CLK);
        check("drop_state_pre", dut.state, PRECHARGE);
        check("drop_pre_outputs", {RASn, UCASn, LCASn, MUX_COL, MEMWn, ACC_ACK}, 10'b1111_11_0_1_0);
        @(negedge CLK);
        check("drop_state_idle", dut.state, IDLE);

        // Tick landing on the REF_PRE decrement with two refreshes owed.
        do_reset();
        access_start(2'd3, 1'b0, 1'b0, 1'b1, 2, bc);
        wait_cyc(3 * RI - 6);
        check("owed_two", dut.u_timer.pending, 2);
        access_end();
        wait_cyc(3 * RI - 1);
        check("coincide_in_ref_pre", dut.state, REF_PRE);
        check("coincide_pending_before", dut.u_timer.pending, 2);
        @(negedge CLK);
        check("coincide_pending_after", dut.u_timer.pending, 2);
        wait_cyc(3 * RI + 4);
        check("coincide_next_refresh", dut.u_timer.pending, 1);

        // Long access saturates the backlog; the next access waits behind a
        // refresh (three refresh states plus the IDLE they return to).
        do_reset();
        access_start(2'd0, 1'b1, 1'b0, 1'b0, 2, bc);
        wait_cyc(4 * RI);
        check("saturated_pending", dut.u_timer.pending, MP);
        wait_cyc(5 * RI + 1);
        check("tick_dropped_at_max", dut.u_timer.pending, MP);
        check("long_access_ack", ACC_ACK, 1);
        access_end();
        @(negedge CLK);
        access_start(2'd1, 1'b0, 1'b0, 1'b0, 2 + 5, bc);
        check("refresh_ahead_of_access", bc, 3);
        check("pending_after_forced", dut.u_timer.pending, MP - 1);
        access_end();

        // Randomized accesses with idle gaps; refreshes slot in between.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(1, 20)) @(negedge CLK);
            access_start(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, bc);
            repeat ($urandom_range(0, 15)) @(negedge CLK);
            access_end();
        end
        repeat (12) @(negedge CLK);
        #1;
        // Every tick since reset is either refreshed already or still owed.
        check("refresh_conservation", ref_count + int'(dut.u_timer.pending), cyc / RI);
        check("scoreboard_drained", acc_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
